// File: rtl/m_matrix_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
// Scan FSM states, default geometry and index-width helper.
package m_matrix_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ON,
        ST_BLANK
    } scan_state_t;

    // Bits needed to index n entries, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_matrix_scan_driver_if.sv
// Frame-store write port and bank-swap handshake of the scan driver.
// master = control logic, slave = scan driver.
interface m_matrix_scan_driver_if
    import m_matrix_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);

    logic                     wr_en;
    logic [idx_w(ROWS)-1:0]   wr_row;
    logic [COLS-1:0]          wr_data;
    logic                     swap_req;
    logic                     swap_ack;

    modport master (
        output wr_en, wr_row, wr_data, swap_req,
        input  swap_ack
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req,
        output swap_ack
    );

endinterface

// File: rtl/m_matrix_row_buf.sv
// Double-buffered ROWS x COLS frame store.
// Writes hit the back bank; reads see the display bank, or the back bank when flip is set.
module m_matrix_row_buf
    import m_matrix_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int RW  = idx_w(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            flip,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    localparam logic [RW:0] ROWS_L = ROWS[RW:0];

    logic [COLS-1:0] bank [2][ROWS];
    logic            sel;

    // A flipping read already sees the bank that becomes the display bank.
    assign rd_data = bank[sel ^ flip][rd_row];

    // Back-bank writes (pre-toggle bank) and display-bank toggling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
            sel <= 1'b0;
        end else begin
            if (wr_en && ({1'b0, wr_row} < ROWS_L)) begin
                bank[~sel][wr_row] <= wr_data;
            end
            if (flip) begin
                sel <= ~sel;
            end
        end
    end

endmodule

// File: rtl/m_matrix_scan_driver.sv
// Time-multiplexed LED matrix scan driver with dwell, blank gap and bank swap.
// Optional MATRIX_BRIGHTNESS_EN adds a 4-bit brightness input (column PWM per dwell).
module m_matrix_scan_driver
    import m_matrix_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    m_matrix_scan_driver_if.slave bus,
    output logic [ROWS-1:0]       row_sel,
    output logic [COLS-1:0]       col_data,
    output logic                  frame_start
);

    localparam int RW   = idx_w(ROWS);
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = idx_w(CMAX);

    localparam logic [CW-1:0]   DWELL_END = CW'(DWELL - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK - 1);
    localparam logic [RW-1:0]   ROW_END   = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ONE_HOT0  = ROWS'(1);

    scan_state_t     state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   cnt;
    logic [COLS-1:0] col_reg;
    logic            pending;
    logic            apply;
    logic [COLS-1:0] rd_data;

`ifdef MATRIX_BRIGHTNESS_EN
    localparam int STEP = DWELL / 16;
    logic [CW:0]     lim;
`endif

    // Swap lands only on an enabled row-0 load; en low holds it back.
    assign apply = en && (state == ST_LOAD) && (row == '0) && pending;

    m_matrix_row_buf #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_row  (bus.wr_row),
        .wr_data (bus.wr_data),
        .flip    (apply),
        .rd_row  (row),
        .rd_data (rd_data)
    );

    // Scan FSM with registered strobes, columns and pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            row          <= '0;
            cnt          <= '0;
            col_reg      <= '0;
            pending      <= 1'b0;
            row_sel      <= '0;
            col_data     <= '0;
            frame_start  <= 1'b0;
            bus.swap_ack <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
            lim          <= '0;
`endif
        end else begin
            frame_start  <= 1'b0;
            bus.swap_ack <= 1'b0;
            pending      <= bus.swap_req | (pending & ~apply);
            if (state != ST_IDLE && !en) begin
                state    <= ST_IDLE;
                row      <= '0;
                row_sel  <= '0;
                col_data <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        row_sel  <= '0;
                        col_data <= '0;
                        row      <= '0;
                        if (en) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        row_sel      <= '0;
                        col_data     <= '0;
                        col_reg      <= rd_data;
                        frame_start  <= (row == '0);
                        bus.swap_ack <= apply;
                        cnt          <= '0;
                        state        <= ST_ON;
`ifdef MATRIX_BRIGHTNESS_EN
                        lim <= (CW+1)'((32'(brightness) + 1) * STEP);
`endif
                    end
                    ST_ON: begin
                        row_sel <= ONE_HOT0 << row;
`ifdef MATRIX_BRIGHTNESS_EN
                        col_data <= ({1'b0, cnt} < lim) ? col_reg : '0;
`else
                        col_data <= col_reg;
`endif
                        if (cnt == DWELL_END) begin
                            cnt   <= '0;
                            state <= ST_BLANK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        row_sel  <= '0;
                        col_data <= '0;
                        if (cnt == BLANK_END) begin
                            cnt   <= '0;
                            row   <= (row == ROW_END) ? '0 : row + 1'b1;
                            state <= ST_LOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_matrix_scan_driver.sv
// Bench for m_matrix_scan_driver: time-based reference model plus directed checks.
// A second 5-row instance exercises out-of-range row writes.
module tb_m_matrix_scan_driver;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int RP    = 1 + DWELL + BLANK;
    localparam int FP    = ROWS * RP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [3:0] brightness = 4'd15;
`endif

    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
    logic            frame_start;
    logic [4:0]      row_sel5;
    logic [7:0]      col_data5;
    logic            frame_start5;

    m_matrix_scan_driver_if #(.ROWS(4), .COLS(8)) bus ();
    m_matrix_scan_driver_if #(.ROWS(5), .COLS(8)) bus5 ();

    always #5 clk = ~clk;

    m_matrix_scan_driver #(
        .ROWS(4), .COLS(8), .DWELL(16), .BLANK(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .bus         (bus),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    m_matrix_scan_driver #(
        .ROWS(5), .COLS(8), .DWELL(16), .BLANK(2)
    ) dut5 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .bus         (bus5),
        .row_sel     (row_sel5),
        .col_data    (col_data5),
        .frame_start (frame_start5)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outputs follow from elapsed edges since scanning began.
    logic            act_m;
    int              k;
    logic            pend_m;
    logic            disp_m;
    logic [7:0]      bank_m [2][4];
    logic [7:0]      latch_m;
    int              lim_m;
    logic [3:0]      e_rs;
    logic [7:0]      e_col;
    logic            e_fs;
    logic            e_ack;

    always @(posedge clk) begin
        int   ph;
        int   r;
        logic ld;
        logic fl;
        if (!rst) begin
            act_m  = 1'b0;
            k      = 0;
            pend_m = 1'b0;
            disp_m = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 4; i++) bank_m[b][i] = 8'h00;
            latch_m = 8'h00;
            lim_m   = DWELL;
            e_rs    = '0;
            e_col   = '0;
            e_fs    = 1'b0;
            e_ack   = 1'b0;
        end else begin
            if (act_m && !en) act_m = 1'b0;
            else if (!act_m) begin
                if (en) begin
                    act_m = 1'b1;
                    k     = 0;
                end
            end else k++;
            ld = act_m && (k >= 1) && ((k - 1) % RP == 0);
            r  = (act_m && k >= 1) ? ((k - 1) / RP) % ROWS : 0;
            fl = ld && (r == 0) && pend_m;
            if (ld) begin
                latch_m = bank_m[disp_m ^ fl][r];
`ifdef MATRIX_BRIGHTNESS_EN
                lim_m = (int'(brightness) + 1) * (DWELL / 16);
`else
                lim_m = DWELL;
`endif
            end
            if (bus.wr_en) bank_m[~disp_m][bus.wr_row] = bus.wr_data;
            if (fl) disp_m = ~disp_m;
            pend_m = bus.swap_req || (pend_m && !fl);
            e_fs   = ld && (r == 0);
            e_ack  = fl;
            ph     = k - 2;
            if (act_m && ph >= 0 && (ph % RP) < DWELL) begin
                e_rs  = 4'(1 << ((ph / RP) % ROWS));
                e_col = ((ph % RP) < lim_m) ? latch_m : 8'h00;
            end else begin
                e_rs  = '0;
                e_col = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_row_sel",  32'(row_sel),      32'(e_rs));
        chk("m_col_data", 32'(col_data),     32'(e_col));
        chk("m_frame",    32'(frame_start),  32'(e_fs));
        chk("m_swap_ack", 32'(bus.swap_ack), 32'(e_ack));
    end

    logic [7:0] cap  [4];
    logic [7:0] cap5 [5];

    task automatic write_row(input int r, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = r[1:0];
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_row5(input int r, input logic [7:0] d);
        bus5.wr_en   = 1'b1;
        bus5.wr_row  = r[2:0];
        bus5.wr_data = d;
        step();
        bus5.wr_en   = 1'b0;
    endtask

    task automatic capture();
        for (int j = 0; j < 4; j++) cap[j] = 8'h00;
        repeat (FP) begin
            step();
            for (int j = 0; j < 4; j++) if (row_sel[j]) cap[j] = col_data;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int g;
        int a;
        int bad;
        int hi;
        int exp_on;
        logic nz;
        logic ee;
        bus.wr_en = 0; bus.wr_row = 0; bus.wr_data = 0; bus.swap_req = 0;
        bus5.wr_en = 0; bus5.wr_row = 0; bus5.wr_data = 0; bus5.swap_req = 0;

        repeat (3) step();
        chk("rst_row_sel", 32'(row_sel), 0);
        chk("rst_col", 32'(col_data), 0);
        chk("rst_frame", 32'(frame_start), 0);
        chk("rst_ack", 32'(bus.swap_ack), 0);
        rst = 1'b1;
        repeat (2) step();
        chk("idle_row_sel", 32'(row_sel), 0);

        // 1: scan timing
        en = 1'b1;
        step();
        n = 0;
        while (row_sel == 0 && n < 10) begin step(); n++; end
        chk("first_on_latency", n, 2);
        chk("first_row", 32'(row_sel), 32'h1);
        chk("first_col_dark", 32'(col_data), 0);
        m = 0;
        while (row_sel == 4'b0001 && m < 100) begin m++; step(); end
        chk("dwell_len", m, 16);
        g = 0;
        while (row_sel == 0 && g < 100) begin g++; step(); end
        chk("gap_len", g, 3);
        chk("second_row", 32'(row_sel), 32'h2);
        n = 0;
        while (!frame_start && n < 200) begin step(); n++; end
        chk("fs_seen", 32'(frame_start), 1);
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 200);
        chk("frame_period", n, 76);
        step();
        chk("fs_then_row0", 32'(row_sel), 32'h1);

        // 2: fill back bank and swap
        write_row(0, 8'hA5);
        write_row(1, 8'h3C);
        write_row(2, 8'hFF);
        write_row(3, 8'h01);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        nz = 1'b0;
        n = 0;
        while (!bus.swap_ack && n < 200) begin
            if (col_data != 0) nz = 1'b1;
            step();
            n++;
        end
        chk("swap_ack_seen", 32'(bus.swap_ack), 1);
        chk("old_bank_dark", 32'(nz), 0);
        step();
        chk("row0_new_sel", 32'(row_sel), 32'h1);
        chk("row0_new_data", 32'(col_data), 32'hA5);
        capture();
        chk("frame_r0", 32'(cap[0]), 32'hA5);
        chk("frame_r1", 32'(cap[1]), 32'h3C);
        chk("frame_r2", 32'(cap[2]), 32'hFF);
        chk("frame_r3", 32'(cap[3]), 32'h01);

        // 3: three requests in one frame merge into one swap
        write_row(0, 8'h11);
        write_row(1, 8'h22);
        write_row(2, 8'h33);
        write_row(3, 8'h44);
        n = 0;
        while (!frame_start && n < 200) begin step(); n++; end
        a = 0;
        for (int i = 0; i < 3; i++) begin
            repeat (3) step();
            bus.swap_req = 1'b1;
            step();
            bus.swap_req = 1'b0;
        end
        repeat (160) begin
            step();
            if (bus.swap_ack) a++;
        end
        chk("merged_ack_count", a, 1);
        capture();
        chk("merged_r0", 32'(cap[0]), 32'h11);
        chk("merged_r3", 32'(cap[3]), 32'h44);

        // 4: enable drop during row 2
        n = 0;
        while (row_sel != 4'b0100 && n < 200) begin step(); n++; end
        chk("row2_reached", 32'(row_sel), 32'h4);
        repeat (5) step();
        en = 1'b0;
        step();
        chk("drop_row_sel", 32'(row_sel), 0);
        chk("drop_col", 32'(col_data), 0);
        repeat (4) step();
        chk("idle_row_sel2", 32'(row_sel), 0);
        en = 1'b1;
        step();
        n = 0;
        while (!frame_start && n < 10) begin step(); n++; end
        chk("restart_fs_latency", n, 1);
        step();
        chk("restart_row0", 32'(row_sel), 32'h1);
        chk("restart_data", 32'(col_data), 32'h11);

        // 5: out-of-range row writes on a 5-row instance
        write_row5(0, 8'h10);
        write_row5(1, 8'h11);
        write_row5(2, 8'h12);
        write_row5(3, 8'h13);
        write_row5(4, 8'h14);
        write_row5(5, 8'hEE);
        write_row5(7, 8'hEE);
        bus5.swap_req = 1'b1;
        step();
        bus5.swap_req = 1'b0;
        n = 0;
        while (!bus5.swap_ack && n < 250) begin step(); n++; end
        chk("r5_swap_ack", 32'(bus5.swap_ack), 1);
        for (int j = 0; j < 5; j++) cap5[j] = 8'h00;
        ee = 1'b0;
        repeat (2 * 5 * RP) begin
            step();
            if (col_data5 == 8'hEE) ee = 1'b1;
            for (int j = 0; j < 5; j++) if (row_sel5[j]) cap5[j] = col_data5;
        end
        chk("r5_no_stray", 32'(ee), 0);
        chk("r5_row0", 32'(cap5[0]), 32'h10);
        chk("r5_row1", 32'(cap5[1]), 32'h11);
        chk("r5_row3", 32'(cap5[3]), 32'h13);
        chk("r5_row4", 32'(cap5[4]), 32'h14);

        // 6: brightness / full-dwell column drive
`ifdef MATRIX_BRIGHTNESS_EN
        brightness = 4'd3;
        exp_on = 4;
`else
        exp_on = 16;
`endif
        for (int r = 0; r < 4; r++) write_row(r, 8'hFF);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        n = 0;
        while (!bus.swap_ack && n < 200) begin step(); n++; end
        chk("bright_swap_ack", 32'(bus.swap_ack), 1);
        step();
        bad = 0;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (row_sel == 4'b0001) hi++;
            if (col_data !== ((i < exp_on) ? 8'hFF : 8'h00)) bad++;
            step();
        end
        chk("bright_row_sel_len", hi, 16);
        chk("bright_pattern", bad, 0);

        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
